alu_arbiter: RTL and testbench

Shares the single-cycle processor's one ALU between two requesters (e.g. the main datapath and a branch/address unit). Each requester presents an operation with a valid/ready handshake. The arbiter grants one requester, registers its operands, drives the ALU for one cycle, captures the result and holds it until the requester accepts it. The ALU itself is external and purely combinational; this block owns every ALU input.

---
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_arbiter #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [1:0]   req0_op,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [W-1:0] req0_r,
   input  logic         req0_src,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [1:0]   req1_op,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [W-1:0] req1_r,
   input  logic         req1_src,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp_result,
   output logic         rsp_zero,
   output logic         rsp_err,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [W-1:0] alu_r,
   output logic [1:0]   alu_control,
   output logic         alu_src,
   input  logic [W-1:0] alu_c,
   input  logic         alu_zero
);

   localparam logic [1:0] OP_CMP = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t       r_state;
   logic         r_ptr;
   logic         r_gnt;
   logic [1:0]   r_op;
   logic [W-1:0] r_a;
   logic [W-1:0] r_b;
   logic [W-1:0] r_r;
   logic         r_src;
   logic [W-1:0] r_result;
   logic         r_zero;
   logic         r_err;
   logic         r_rsp0_valid;
   logic         r_rsp1_valid;

   logic         w_any;
   logic         w_win;
   logic [1:0]   w_op;
   logic [W-1:0] w_a;
   logic [W-1:0] w_b;
   logic [W-1:0] w_r;
   logic         w_src;
   logic         w_release;

   // Winner selection: a lone requester always wins; ties go to the one not granted last.
   always_comb begin
      w_any = req0_valid | req1_valid;
      w_win = req1_valid & ~req0_valid;
      if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         w_win = 1'b0;
`else
         w_win = ~r_ptr;
`endif
      end
   end

   always_comb begin
      w_op  = w_win ? req1_op  : req0_op;
      w_a   = w_win ? req1_a   : req0_a;
      w_b   = w_win ? req1_b   : req0_b;
      w_r   = w_win ? req1_r   : req0_r;
      w_src = w_win ? req1_src : req0_src;
   end

   assign w_release  = r_gnt ? rsp1_ready : rsp0_ready;
   assign req0_ready = (r_state == S_IDLE) & req0_valid & ~w_win;
   assign req1_ready = (r_state == S_IDLE) & req1_valid &  w_win;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= 1'b1;
         r_gnt        <= 1'b0;
         r_op         <= 2'b00;
         r_a          <= '0;
         r_b          <= '0;
         r_r          <= '0;
         r_src        <= 1'b0;
         r_result     <= '0;
         r_zero       <= 1'b0;
         r_err        <= 1'b0;
         r_rsp0_valid <= 1'b0;
         r_rsp1_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_op  <= w_op;
                  r_a   <= w_a;
                  r_b   <= w_b;
                  r_r   <= w_r;
                  r_src <= w_src;
                  r_gnt <= w_win;
                  r_ptr <= w_win;
                  // Illegal ops never reach the ALU and answer immediately.
                  if (w_op == OP_ILL) begin
                     r_result     <= '0;
                     r_zero       <= 1'b0;
                     r_err        <= 1'b1;
                     r_rsp0_valid <= ~w_win;
                     r_rsp1_valid <= w_win;
                     r_state      <= S_RESP;
                  end else begin
                     r_state <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               // The ALU only drives its zero flag for compare; add/sub zero is derived here.
               if (r_op == OP_CMP) begin
                  r_result <= '0;
                  r_zero   <= alu_zero;
               end else begin
                  r_result <= alu_c;
                  r_zero   <= (alu_c == '0);
               end
               r_err        <= 1'b0;
               r_rsp0_valid <= ~r_gnt;
               r_rsp1_valid <= r_gnt;
               r_state      <= S_RESP;
            end
            S_RESP: begin
               if (w_release) begin
                  r_rsp0_valid <= 1'b0;
                  r_rsp1_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rsp0_valid  = r_rsp0_valid;
   assign rsp1_valid  = r_rsp1_valid;
   assign rsp_result  = r_result;
   assign rsp_zero    = r_zero;
   assign rsp_err     = r_err;
   assign alu_a       = r_a;
   assign alu_b       = r_b;
   assign alu_r       = r_r;
   assign alu_control = r_op;
   assign alu_src     = r_src;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors, arbitration sequences and randomized traffic
// against a behavioural model of the ALU sharing rules.
module tb_alu_arbiter;
   localparam int unsigned W = 32;
`ifdef ALU_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         req0_valid, req0_ready, req0_src;
   logic [1:0]   req0_op;
   logic [W-1:0] req0_a, req0_b, req0_r;
   logic         req1_valid, req1_ready, req1_src;
   logic [1:0]   req1_op;
   logic [W-1:0] req1_a, req1_b, req1_r;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_zero, rsp_err;
   logic [W-1:0] alu_a, alu_b, alu_r, alu_c;
   logic [1:0]   alu_control;
   logic         alu_src, alu_zero;
   logic [W-1:0] tb_opnd;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [W-1:0] res;
      logic         zero;
      logic         err;
   } exp_t;

   typedef struct {
      int           n;
      logic [1:0]   op;
      logic [W-1:0] a, b, r;
      logic         src;
      logic [W-1:0] res;
      logic         zero;
      logic         err;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   alu_arbiter #(.W(W)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b), .req0_r(req0_r), .req0_src(req0_src),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b), .req1_r(req1_r), .req1_src(req1_src),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
      .alu_control(alu_control), .alu_src(alu_src),
      .alu_c(alu_c), .alu_zero(alu_zero)
   );

   // External ALU: zero flag is garbage (1) for add/sub, result is garbage for compare.
   always_comb begin
      tb_opnd  = alu_src ? alu_r : alu_b;
      alu_c    = '1;
      alu_zero = 1'b1;
      case (alu_control)
         2'b00: alu_c = alu_a - tb_opnd;
         2'b01: alu_c = alu_a + tb_opnd;
         2'b10: begin
            alu_c    = (alu_a ^ tb_opnd) | W'(1);
            alu_zero = (alu_a == tb_opnd);
         end
         default: ;
      endcase
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, b, r, input logic src);
      exp_t         m;
      logic [W-1:0] opnd;
      opnd  = src ? r : b;
      m.err = 1'b0;
      case (op)
         2'b00: begin m.res = a - opnd; m.zero = (a == opnd); end
         2'b01: begin m.res = a + opnd; m.zero = (m.res == '0); end
         2'b10: begin m.res = '0; m.zero = (a == opnd); end
         default: begin m.res = '0; m.zero = 1'b0; m.err = 1'b1; end
      endcase
      return m;
   endfunction

   task automatic drive(input int n, input logic v, input logic [1:0] op,
                        input logic [W-1:0] a, b, r, input logic src);
      if (n == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_r = r; req0_src = src;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_r = r; req1_src = src;
      end
   endtask

   task automatic set_rrdy(input int n, input logic v);
      if (n == 0) rsp0_ready = v;
      else        rsp1_ready = v;
   endtask

   function automatic logic rdy(input int n);
      return (n == 0) ? req0_ready : req1_ready;
   endfunction

   function automatic logic rspv(input int n);
      return (n == 0) ? rsp0_valid : rsp1_valid;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
      drive(1, 1'b0, 2'b00, '0, '0, '0, 1'b0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Called at the negedge after the accept edge: checks latency, result, hold and release.
   task automatic finish_rsp(input int n, input logic [1:0] op, input logic [W-1:0] a,
                             input logic src, input exp_t e, input int hold);
      int lat;
      bit got;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (rspv(n)) begin got = 1'b1; break; end
         if (lat == 1) begin
            chkw("exec_alu_a", alu_a, a);
            chkw("exec_alu_control", W'(alu_control), W'(op));
            chk1("exec_alu_src", alu_src, src);
         end
         @(negedge clk);
         lat++;
      end
      chk1("rsp_seen", got, 1'b1);
      if (!got) return;
      chkw("latency", W'(lat), (op == 2'b11) ? W'(1) : W'(2));
      chkw("rsp_result", rsp_result, e.res);
      chk1("rsp_zero", rsp_zero, e.zero);
      chk1("rsp_err", rsp_err, e.err);
      chk1("other_rsp_low", rspv(1 - n), 1'b0);
      for (int i = 0; i < hold; i++) begin
         set_rrdy(1 - n, 1'($urandom_range(0, 1)));
         @(negedge clk);
         chk1("hold_valid", rspv(n), 1'b1);
         chkw("hold_result", rsp_result, e.res);
      end
      set_rrdy(n, 1'b1);
      set_rrdy(1 - n, 1'b0);
      #1;
      chk1("release_req0_ready", req0_ready, 1'b0);
      chk1("release_req1_ready", req1_ready, 1'b0);
      @(negedge clk);
      set_rrdy(n, 1'b0);
      chk1("released", rspv(n), 1'b0);
   endtask

   task automatic run_txn(input int n, input logic [1:0] op, input logic [W-1:0] a, b, r,
                          input logic src, input exp_t e, input int hold);
      bit got;
      @(negedge clk);
      drive(n, 1'b1, op, a, b, r, src);
      #1;
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rdy(n)) begin got = 1'b1; break; end
         @(negedge clk);
         #1;
      end
      chk1("accept", got, 1'b1);
      if (!got) begin
         drive(n, 1'b0, op, a, b, r, src);
         return;
      end
      chk1("other_ready_low", rdy(1 - n), 1'b0);
      @(negedge clk);
      drive(n, 1'b0, op, a, b, r, src);
      finish_rsp(n, op, a, src, e, hold);
   endtask

   initial begin
      vecs[0] = '{0, 2'b01, 5,            0, 7, 1'b1, 12,           1'b0, 1'b0};
      vecs[1] = '{1, 2'b00, 9,            9, 0, 1'b0, 0,            1'b1, 1'b0};
      vecs[2] = '{1, 2'b10, 3,            4, 0, 1'b0, 0,            1'b0, 1'b0};
      vecs[3] = '{0, 2'b11, 1,            2, 3, 1'b0, 0,            1'b0, 1'b1};
      vecs[4] = '{1, 2'b10, 7,            0, 7, 1'b1, 0,            1'b1, 1'b0};
      vecs[5] = '{0, 2'b00, 0,            1, 9, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[6] = '{0, 2'b01, 32'hFFFFFFFF, 1, 5, 1'b0, 0,            1'b1, 1'b0};
      vecs[7] = '{1, 2'b11, 4,            4, 4, 1'b1, 0,            1'b0, 1'b1};

      do_reset();
      #1;
      chk1("reset_req0_ready", req0_ready, 1'b0);
      chk1("reset_req1_ready", req1_ready, 1'b0);
      chk1("reset_rsp0_valid", rsp0_valid, 1'b0);
      chk1("reset_rsp1_valid", rsp1_valid, 1'b0);
      chkw("reset_rsp_result", rsp_result, '0);
      chk1("reset_rsp_zero", rsp_zero, 1'b0);
      chk1("reset_rsp_err", rsp_err, 1'b0);
      chkw("reset_alu_a", alu_a, '0);
      chkw("reset_alu_b", alu_b, '0);
      chkw("reset_alu_r", alu_r, '0);
      chkw("reset_alu_control", W'(alu_control), '0);
      chk1("reset_alu_src", alu_src, 1'b0);

      // Directed vectors
      foreach (vecs[i]) begin
         run_txn(vecs[i].n, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].src,
                 '{vecs[i].res, vecs[i].zero, vecs[i].err}, (i == 1) ? 3 : 0);
      end

      // Both requesters valid continuously, responses always accepted
      do_reset();
      @(negedge clk);
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      drive(0, 1'b1, 2'b01, 10, 1, 0, 1'b0);
      drive(1, 1'b1, 2'b01, 20, 2, 0, 1'b0);
      for (int c = 0; c < 12; c++) begin
         bit g;
         bit slot;
         #1;
         slot = (c % 3 == 0);
         g    = FIXED ? 1'b0 : 1'((c / 3) % 2);
         chk1("rr_req0_ready", req0_ready, slot && !g);
         chk1("rr_req1_ready", req1_ready, slot && g);
         @(negedge clk);
      end
      drive(0, 1'b0, 2'b00, 0, 0, 0, 1'b0);
      drive(1, 1'b0, 2'b00, 0, 0, 0, 1'b0);
      rsp0_ready = 1'b0;
      rsp1_ready = 1'b0;

      // Backpressure: held response blocks req1
      do_reset();
      @(negedge clk);
      drive(0, 1'b1, 2'b01, 10, 0, 20, 1'b1);
      #1;
      chk1("bp_accept0", req0_ready, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 2'b01, 10, 0, 20, 1'b1);
      drive(1, 1'b1, 2'b01, 1, 1, 0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         #1;
         chk1("bp_rsp0_valid", rsp0_valid, 1'b1);
         chkw("bp_result", rsp_result, 30);
         chk1("bp_req1_ready", req1_ready, 1'b0);
         @(negedge clk);
      end
      rsp0_ready = 1'b1;
      #1;
      chk1("bp_release_no_grant", req1_ready, 1'b0);
      @(negedge clk);
      rsp0_ready = 1'b0;
      #1;
      chk1("bp_req1_granted", req1_ready, 1'b1);
      @(negedge clk);
      drive(1, 1'b0, 2'b01, 1, 1, 0, 1'b0);
      finish_rsp(1, 2'b01, 1, 1'b0, '{32'd2, 1'b0, 1'b0}, 0);

      // Reset during EXEC abandons the transaction and restores the pointer
      run_txn(0, 2'b01, 3, 4, 0, 1'b0, '{32'd7, 1'b0, 1'b0}, 0);
      @(negedge clk);
      drive(0, 1'b1, 2'b01, 1, 2, 0, 1'b0);
      #1;
      chk1("mid_accept", req0_ready, 1'b1);
      @(negedge clk);
      drive(0, 1'b0, 2'b01, 1, 2, 0, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk1("mid_rsp0_valid", rsp0_valid, 1'b0);
      chk1("mid_rsp1_valid", rsp1_valid, 1'b0);
      chkw("mid_alu_a", alu_a, '0);
      chkw("mid_alu_b", alu_b, '0);
      chkw("mid_alu_control", W'(alu_control), '0);
      chkw("mid_rsp_result", rsp_result, '0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk1("mid_no_rsp", rsp0_valid | rsp1_valid, 1'b0);
      end
      drive(0, 1'b1, 2'b00, 5, 5, 0, 1'b0);
      drive(1, 1'b1, 2'b00, 6, 6, 0, 1'b0);
      #1;
      chk1("mid_next_req0_wins", req0_ready, 1'b1);
      chk1("mid_next_req1_loses", req1_ready, 1'b0);
      drive(0, 1'b0, 2'b00, 0, 0, 0, 1'b0);
      drive(1, 1'b0, 2'b00, 0, 0, 0, 1'b0);

      // Randomized traffic against the model
      do_reset();
      begin
         bit last;
         last = 1'b1;
         for (int it = 0; it < 150; it++) begin
            bit           v[2];
            logic [1:0]   op[2];
            logic [W-1:0] a[2], b[2], r[2];
            logic         src[2];
            int           w;
            exp_t         e;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
               v[k]   = 1'($urandom_range(0, 1));
               op[k]  = 2'($urandom_range(0, 3));
               a[k]   = $urandom;
               b[k]   = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
               r[k]   = ($urandom_range(0, 3) == 0) ? (W'(0) - a[k]) : $urandom;
               src[k] = 1'($urandom_range(0, 1));
            end
            if (!v[0] && !v[1]) v[0] = 1'b1;
            if (v[0] && v[1]) w = FIXED ? 0 : (last ? 0 : 1);
            else              w = v[1] ? 1 : 0;
            drive(0, v[0], op[0], a[0], b[0], r[0], src[0]);
            drive(1, v[1], op[1], a[1], b[1], r[1], src[1]);
            #1;
            chk1("rnd_req0_ready", req0_ready, w == 0);
            chk1("rnd_req1_ready", req1_ready, w == 1);
            last = 1'(w);
            e = model(op[w], a[w], b[w], r[w], src[w]);
            @(negedge clk);
            drive(0, 1'b0, 2'b00, '0, '0, '0, 1'b0);
            drive(1, 1'b0, 2'b00, '0, '0, '0, 1'b0);
            finish_rsp(w, op[w], a[w], src[w], e, $urandom_range(0, 3));
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
